// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin arbiter driving a registered-select 4:1 data mux with bounded grant bursts
module rr_mux_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [3:0]       Req,
  input  logic [WIDTH-1:0] In0,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic [WIDTH-1:0] In3,
  output logic [3:0]       Gnt,
  output logic             Sel1,
  output logic             Sel0,
  output logic [WIDTH-1:0] Out,
  output logic             OutValid
);
  typedef enum logic {IDLE, GRANT} state_t;
  localparam logic [7:0] LAST = 8'(MAX_HOLD - 1);
  state_t r_state, w_state;
  logic [1:0] r_sel, w_sel, r_ptr, w_ptr, w_start, w_win, w_idx;
  logic [3:0] r_gnt, w_req;
  logic [7:0] r_hold, w_hold;
  logic w_found, w_rel;
  always_comb begin
    w_rel   = !Req[r_sel] || r_hold == LAST;
    w_req   = r_state == GRANT ? Req & ~r_gnt : Req;
    w_start = r_state == GRANT ? r_sel + 2'd1 : r_ptr;
    w_found = 1'b0;
    w_win   = 2'd0;
    w_idx   = 2'd0;
    // scan farthest offset first so the nearest requester after w_start wins
    for (int k = 3; k >= 0; k--) begin
      w_idx = w_start + 2'(k);
      if (w_req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
    w_state = r_state;
    w_sel   = r_sel;
    w_hold  = r_hold;
    w_ptr   = r_ptr;
    if (r_state == IDLE) begin
      if (w_found) begin
        w_state = GRANT;
        w_sel   = w_win;
        w_hold  = 8'd0;
      end
    end else if (!w_rel) begin
      w_hold = r_hold + 8'd1;
    end else begin
      w_ptr  = r_sel + 2'd1;
      w_hold = 8'd0;
      if (w_found) w_sel = w_win;
      else if (!Req[r_sel]) begin
        w_state = IDLE;
        w_sel   = 2'd0;
      end
    end
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
      r_sel   <= 2'd0;
      r_hold  <= 8'd0;
      r_ptr   <= 2'd0;
      r_gnt   <= 4'd0;
    end else begin
      r_state <= w_state;
      r_sel   <= w_sel;
      r_hold  <= w_hold;
      r_ptr   <= w_ptr;
      r_gnt   <= w_state == GRANT ? 4'b0001 << w_sel : 4'd0;
    end
  end
  assign Gnt          = r_gnt;
  assign {Sel1, Sel0} = r_sel;
  assign OutValid     = r_state == GRANT;
  assign Out = {WIDTH{OutValid}} & (({WIDTH{r_sel == 2'd0}} & In0) | ({WIDTH{r_sel == 2'd1}} & In1) |
                                    ({WIDTH{r_sel == 2'd2}} & In2) | ({WIDTH{r_sel == 2'd3}} & In3));
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: scoreboard bench comparing the arbiter against a behavioural round-robin model
module tb_rr_mux_arbiter;
  localparam int W  = 8;
  localparam int MH = 4;
  logic Clk = 0, Reset = 1;
  logic [3:0] Req = 0;
  logic [W-1:0] In0 = 0, In1 = 0, In2 = 0, In3 = 0;
  logic [3:0] Gnt;
  logic Sel1, Sel0, OutValid;
  logic [W-1:0] Out;

  rr_mux_arbiter #(.WIDTH(W), .MAX_HOLD(MH)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .In0(In0), .In1(In1), .In2(In2), .In3(In3),
    .Gnt(Gnt), .Sel1(Sel1), .Sel0(Sel0), .Out(Out), .OutValid(OutValid)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [3:0]   gnt;
    logic [1:0]   sel;
    logic         v;
    logic [W-1:0] out;
  } exp_t;
  exp_t q[$];
  int checks = 0, passed = 0, cyc = 0;
  int m_owner = -1, m_hold = 0, m_ptr = 0;
  logic [W-1:0] din [4];

  function automatic int search(input logic [3:0] rq, input int start);
    for (int k = 0; k < 4; k++) if (rq[(start + k) % 4]) return (start + k) % 4;
    return -1;
  endfunction

  task automatic model(input logic rst, input logic [3:0] rq);
    int w, c;
    if (rst) begin
      m_owner = -1; m_hold = 0; m_ptr = 0;
    end else if (m_owner < 0) begin
      w = search(rq, m_ptr);
      if (w >= 0) begin m_owner = w; m_hold = 0; end
    end else if (rq[m_owner] && m_hold < MH - 1) begin
      m_hold++;
    end else begin
      c = m_owner;
      m_ptr = (c + 1) % 4;
      w = search(rq & ~(4'b0001 << c), m_ptr);
      if (w >= 0) begin m_owner = w; m_hold = 0; end
      else if (rq[c]) m_hold = 0;
      else m_owner = -1;
    end
  endtask

  task automatic step(input logic rst, input logic [3:0] rq);
    exp_t e;
    @(negedge Clk);
    for (int i = 0; i < 4; i++) din[i] = W'($urandom);
    Reset = rst; Req = rq;
    In0 = din[0]; In1 = din[1]; In2 = din[2]; In3 = din[3];
    @(posedge Clk);
    model(rst, rq);
    e.v   = m_owner >= 0;
    e.gnt = e.v ? 4'b0001 << m_owner : 4'd0;
    e.sel = e.v ? 2'(m_owner) : 2'd0;
    e.out = e.v ? din[m_owner] : '0;
    q.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if ({Gnt, Sel1, Sel0, OutValid, Out} == e) passed++;
        else $display("FAIL cycle%0d gnt/sel/valid/out got %b/%b%b/%b/%h expected %b/%b/%b/%h",
                      cyc, Gnt, Sel1, Sel0, OutValid, Out, e.gnt, e.sel, e.v, e.out);
      end
    end
  end

  initial begin
    repeat (2) step(1'b1, 4'b1111);
    step(1'b0, 4'b0100);
    step(1'b0, 4'b0100);
    repeat (2) step(1'b0, 4'b0000);
    repeat (20) step(1'b0, 4'b1111);
    repeat (10) step(1'b0, 4'b0010);
    step(1'b1, 4'b0000);
    repeat (2) step(1'b0, 4'b1001);
    repeat (2) step(1'b0, 4'b1000);
    repeat (3) step(1'b0, 4'b0011);
    repeat (2) step(1'b0, 4'b0010);
    step(1'b1, 4'b0010);
    repeat (3) step(1'b0, 4'b0011);
    step(1'b0, 4'b0000);
    for (int n = 0; n < 400; n++) step($urandom_range(0, 49) == 0, 4'($urandom));
    step(1'b0, 4'b0000);
    repeat (3) @(posedge Clk);
    #2;
    checks++;
    if (q.size() == 0) passed++;
    else $display("FAIL drain queue left %0d expected 0", q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
